multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore-style main control FSM for the multicycle RV32I core.
- Sequences the shared ALU, memory port, register file and PC/IR write enables.
- Drives extend_ctrl to the immediate extender (000 I, 001 S, 010 B, 011 U, 100 J).
- Sits between the instruction register and the datapath muxes; handles variable-latency memory via a req/ready handshake with timeout.

Parameters:
WAIT_TIMEOUT, 255, max cycles mem_req may stay high without mem_ready before bus error; 0 disables timeout
CNT_W, 8, width of the wait counter; WAIT_TIMEOUT must fit in CNT_W bits

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
instr  in  32  instruction register contents (stable from DECODE onward)
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_write  out  1  access is a write (valid with mem_req)
adr_src  out  1  memory address: 0 = PC, 1 = ALUOut register
ir_write  out  1  load IR and OldPC
pc_write  out  1  load PC from result bus
reg_write  out  1  register-file write strobe
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
alu_src_b  out  2  00 rs2, 01 imm_out, 10 constant 4
alu_op  out  2  00 add, 01 subtract/compare, 10 funct3/funct7 decode
result_src  out  2  00 ALUOut reg, 01 mem read data, 10 ALU result direct
extend_ctrl  out  3  immediate format to extender
illegal  out  1  sticky: unsupported opcode/funct3 decoded
bus_err  out  1  sticky: memory wait timeout
state  out  4  current state, debug

Behaviour:
Clock and reset:
- One clock domain.
- Reset is synchronous and active-low: state <= FETCH, wait counter <= 0, illegal <= 0, bus_err <= 0.
- While rst_n = 0, all strobes (mem_req, mem_write, ir_write, pc_write, reg_write) are 0, all selects are 0, and extend_ctrl = 000.
- Reset mid-access aborts the access; no write strobe is issued.

extend_ctrl (combinational from instr[6:0], all states): lw/I-ALU 000, sw 001, branch 010, lui/auipc 011, jal 100, others 000.

States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, UIMM 11, TRAP 12.
- FETCH: mem_req = 1, adr_src = 0, a = 00, b = 10, alu_op = 00, result_src = 10. On mem_ready, same cycle: ir_write = 1, pc_write = 1, then -> DECODE. Otherwise hold.
- DECODE: a = 01, b = 01, add (branch/jump target into ALUOut). Next state by opcode:
  - 0000011, 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 with funct3 000/001 -> BRANCH
  - 1101111 -> JAL
  - 0110111, 0010111 -> UIMM
  - anything else -> TRAP, setting illegal.
- MEMADR: a = 10, b = 01, add. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: mem_req = 1, adr_src = 1. On mem_ready -> MEMWB.
- MEMWB: result_src = 01, reg_write = 1 -> FETCH.
- MEMWRITE: mem_req = 1, mem_write = 1, adr_src = 1. On mem_ready -> FETCH.
- EXECR: a = 10, b = 00, alu_op = 10 -> ALUWB.
- EXECI: a = 10, b = 01, alu_op = 10 -> ALUWB.
- ALUWB: result_src = 00, reg_write = 1 -> FETCH.
- BRANCH: a = 10, b = 00, alu_op = 01, result_src = 00. pc_write = zero for funct3 000 (beq), ~zero for funct3 001 (bne). -> FETCH.
- JAL: a = 01, b = 10, add, result_src = 00, pc_write = 1 (PC <- target) -> ALUWB (link = OldPC + 4).
- UIMM: a = 11 for lui, 01 for auipc; b = 01; add -> ALUWB.
- TRAP: all strobes 0; remains until reset.

Wait counter:
- Cleared on entry to any state and whenever mem_ready = 1; increments each cycle mem_req = 1 and mem_ready = 0.
- When it reaches WAIT_TIMEOUT (WAIT_TIMEOUT != 0) with mem_ready still 0: -> TRAP, bus_err <= 1, no ir_write/reg_write.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- mem_ready and timeout in the same cycle: mem_ready wins.

Latencies with zero-wait memory (mem_ready = 1 on first request cycle):
- R/I/lui/auipc: 4 cycles
- lw: 5 cycles
- sw: 4 cycles
- branch: 3 cycles
- jal: 4 cycles

Test Plan:
- lw 0x00452283, mem_ready low 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; reg_write = 1 only in state 4 with result_src = 01; extend_ctrl = 000.
- sw 0x00552223 zero-wait -> mem_write = 1, adr_src = 1 for exactly one cycle; extend_ctrl = 001; no reg_write.
- beq 0x00208463 with zero = 1, then zero = 0 -> pc_write = 1 in BRANCH only when zero = 1; extend_ctrl = 010; 3 cycles each.
- jal 0x008000EF -> states 0,1,10,8,0; pc_write in JAL, reg_write in ALUWB; extend_ctrl = 100.
- Opcode 0x0000007F -> TRAP after DECODE, illegal = 1 and stays 1; no strobes until rst_n low for one clk edge, then FETCH with illegal = 0.
- WAIT_TIMEOUT = 4, mem_ready held 0 in FETCH -> TRAP after 4 request cycles with bus_err = 1 and ir_write never asserted.
- rst_n low during MEMWRITE wait -> next cycle state = 0, mem_req = 0 while reset held.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Moore-style main control FSM for the multicycle RV32I core. It sequences
//   the shared ALU, the single memory port, the register file and the PC/IR
//   write enables. It also selects the immediate format for the extender.
//   Memory accesses use a req/ready handshake. A wait counter turns a stalled
//   access into a bus error.
//
// Parameters
//   WAIT_TIMEOUT : max cycles mem_req may stay high without mem_ready
//                  (0 disables the timeout)
//   CNT_W        : wait counter width (WAIT_TIMEOUT must fit)
//
// Ports
//   clk, rst_n   : clock, synchronous active-low reset
//   instr        : instruction register contents
//   zero         : ALU zero flag (branch decision)
//   mem_ready    : memory completes the current access this cycle
//   mem_req, mem_write, adr_src        : memory port control
//   ir_write, pc_write, reg_write      : architectural state strobes
//   alu_src_a, alu_src_b, alu_op       : ALU operand / operation selects
//   result_src   : result bus select
//   extend_ctrl  : immediate format (000 I, 001 S, 010 B, 011 U, 100 J)
//   illegal      : sticky, unsupported opcode/funct3 decoded
//   bus_err      : sticky, memory wait timeout
//   state        : current FSM state (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  result_src,
    output logic [2:0]  extend_ctrl,
    output logic        illegal,
    output logic        bus_err,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_UIMM     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Counter value seen on the last permitted request cycle.
    // A count of WAIT_TIMEOUT-1 plus one more stalled cycle reaches WAIT_TIMEOUT.
    localparam logic [CNT_W-1:0] LAST_WAIT =
        (WAIT_TIMEOUT == 0) ? '0 : CNT_W'(WAIT_TIMEOUT - 1);

    logic [6:0] opcode;
    logic [2:0] funct3;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Only the opcode and funct3 fields steer the sequencer.
    logic unused_instr_bits;
    assign unused_instr_bits = &{1'b0, instr[31:15], instr[11:7]};

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             illegal_reg, illegal_next;
    logic             bus_err_reg, bus_err_next;

    // Raw (pre-reset-gating) control values
    logic       mem_req_c, mem_write_c, adr_src_c;
    logic       ir_write_c, pc_write_c, reg_write_c;
    logic [1:0] alu_src_a_c, alu_src_b_c, alu_op_c, result_src_c;
    logic [2:0] extend_c;
    logic       timeout_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            illegal_reg  <= 1'b0;
            bus_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            illegal_reg  <= illegal_next;
            bus_err_reg  <= bus_err_next;
        end
    end

    // Immediate format depends only on the opcode, in every state.
    always_comb begin
        extend_c = 3'b000;
        case (opcode)
            OP_STORE:         extend_c = 3'b001;
            OP_BRANCH:        extend_c = 3'b010;
            OP_LUI, OP_AUIPC: extend_c = 3'b011;
            OP_JAL:           extend_c = 3'b100;
            default:          extend_c = 3'b000;
        endcase
    end

    // The stall limit is reached only if this cycle is also a stalled request.
    // A mem_ready in the same cycle takes priority, because the memory states
    // test mem_ready first.
    assign timeout_hit = (WAIT_TIMEOUT != 0) && (wait_cnt_reg == LAST_WAIT);

    always_comb begin
        state_next   = state_reg;
        illegal_next = illegal_reg;
        bus_err_next = bus_err_reg;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 2'b00;
        result_src_c = 2'b00;

        case (state_reg)
            S_FETCH: begin
                // PC + 4 is computed while the fetch is pending.
                // It is written to PC on the same cycle as the IR.
                mem_req_c    = 1'b1;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    bus_err_next = 1'b1;
                    state_next   = S_TRAP;
                end
            end
            S_DECODE: begin
                // Speculatively form OldPC + imm (branch/jump target) in ALUOut.
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECR;
                    OP_I:              state_next = S_EXECI;
                    OP_BRANCH: begin
                        if (funct3 == 3'b000 || funct3 == 3'b001) begin
                            state_next = S_BRANCH;
                        end else begin
                            illegal_next = 1'b1;
                            state_next   = S_TRAP;
                        end
                    end
                    OP_JAL:           state_next = S_JAL;
                    OP_LUI, OP_AUIPC: state_next = S_UIMM;
                    default: begin
                        illegal_next = 1'b1;
                        state_next   = S_TRAP;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                state_next  = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (timeout_hit) begin
                    bus_err_next = 1'b1;
                    state_next   = S_TRAP;
                end
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                state_next   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (timeout_hit) begin
                    bus_err_next = 1'b1;
                    state_next   = S_TRAP;
                end
            end
            S_EXECR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b00;
                alu_op_c    = 2'b10;
                state_next  = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                alu_op_c    = 2'b10;
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_next  = S_FETCH;
            end
            S_BRANCH: begin
                // The target already sits in ALUOut from DECODE.
                // Here the ALU only compares rs1 with rs2.
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b01;
                pc_write_c  = funct3[0] ? ~zero : zero;
                state_next  = S_FETCH;
            end
            S_JAL: begin
                // Jump to ALUOut while computing the link value OldPC + 4.
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                pc_write_c  = 1'b1;
                state_next  = S_ALUWB;
            end
            S_UIMM: begin
                // lui uses a zero base and auipc uses OldPC.
                // instr[5] tells the two opcodes apart.
                alu_src_a_c = instr[5] ? 2'b11 : 2'b01;
                alu_src_b_c = 2'b01;
                state_next  = S_ALUWB;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_TRAP;
            end
        endcase
    end

    // The counter restarts on every state change and on each completed access.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (state_next != state_reg || mem_ready) begin
            wait_cnt_next = '0;
        end else if (mem_req_c) begin
            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
    end

    // While reset is held, every strobe and select reads as zero.
    // A pending access is dropped without any write strobe.
    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        result_src  = 2'b00;
        extend_ctrl = 3'b000;
        if (rst_n) begin
            mem_req     = mem_req_c;
            mem_write   = mem_write_c;
            adr_src     = adr_src_c;
            ir_write    = ir_write_c;
            pc_write    = pc_write_c;
            reg_write   = reg_write_c;
            alu_src_a   = alu_src_a_c;
            alu_src_b   = alu_src_b_c;
            alu_op      = alu_op_c;
            result_src  = result_src_c;
            extend_ctrl = extend_c;
        end
    end

    assign illegal = illegal_reg;
    assign bus_err = bus_err_reg;
    assign state   = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0]  extend_ctrl;
    logic        illegal, bus_err;
    logic [3:0]  state;

    multicycle_ctrl #(.WAIT_TIMEOUT(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .extend_ctrl(extend_ctrl),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instructions under test
    localparam logic [31:0] I_LW    = 32'h00452283;
    localparam logic [31:0] I_SW    = 32'h00552223;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_BNE   = 32'h00209463;
    localparam logic [31:0] I_BLT   = 32'h0020C463;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_LUI   = 32'h000012B7;
    localparam logic [31:0] I_AUIPC = 32'h00001297;
    localparam logic [31:0] I_ILL   = 32'h0000007F;

    // Strobes: {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write}
    localparam logic [5:0] S_NONE     = 6'b000000;
    localparam logic [5:0] S_FETCH_OK = 6'b100110;
    localparam logic [5:0] S_FETCH_WT = 6'b100000;
    localparam logic [5:0] S_MRD      = 6'b101000;
    localparam logic [5:0] S_MWR      = 6'b111000;
    localparam logic [5:0] S_RW       = 6'b000001;
    localparam logic [5:0] S_PCW      = 6'b000010;

    // Selects: {alu_src_a, alu_src_b, alu_op, result_src}
    localparam logic [7:0] X_NONE  = 8'b00_00_00_00;
    localparam logic [7:0] X_FETCH = 8'b00_10_00_10;
    localparam logic [7:0] X_DEC   = 8'b01_01_00_00;
    localparam logic [7:0] X_MADR  = 8'b10_01_00_00;
    localparam logic [7:0] X_MWB   = 8'b00_00_00_01;
    localparam logic [7:0] X_EXR   = 8'b10_00_10_00;
    localparam logic [7:0] X_EXI   = 8'b10_01_10_00;
    localparam logic [7:0] X_BR    = 8'b10_00_01_00;
    localparam logic [7:0] X_JAL   = 8'b01_10_00_00;
    localparam logic [7:0] X_LUI   = 8'b11_01_00_00;
    localparam logic [7:0] X_AUI   = 8'b01_01_00_00;

    typedef struct {
        logic        rn;
        logic [31:0] ins;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] ctrl;   // {strobes, selects, extend, illegal, bus_err}
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   failures;

    task automatic add(input logic rn, input logic [31:0] ins, input logic z,
                       input logic rdy, input logic [3:0] st, input logic [5:0] stb,
                       input logic [7:0] sel, input logic [2:0] ext,
                       input logic ill, input logic be);
        vec_t v;
        v.rn   = rn;
        v.ins  = ins;
        v.z    = z;
        v.rdy  = rdy;
        v.st   = st;
        v.ctrl = {stb, sel, ext, ill, be};
        vecs.push_back(v);
    endtask

    function automatic logic [18:0] got_ctrl();
        return {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, extend_ctrl, illegal, bus_err};
    endfunction

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0b exp=%0b", name, got, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        instr     = I_LW;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // rn, instr, zero, rdy, state, strobes, selects, ext, illegal, bus_err
        // Reset held: everything gated low even with mem_ready high
        add(0, I_LW,   0, 1,  0, S_NONE,     X_NONE,  3'b000, 0, 0);
        // lw with two wait cycles in MEMREAD: 0,1,2,3,3,3,4
        add(1, I_LW,   0, 1,  0, S_FETCH_OK, X_FETCH, 3'b000, 0, 0);
        add(1, I_LW,   0, 0,  1, S_NONE,     X_DEC,   3'b000, 0, 0);
        add(1, I_LW,   0, 1,  2, S_NONE,     X_MADR,  3'b000, 0, 0);
        add(1, I_LW,   0, 0,  3, S_MRD,      X_NONE,  3'b000, 0, 0);
        add(1, I_LW,   0, 0,  3, S_MRD,      X_NONE,  3'b000, 0, 0);
        add(1, I_LW,   0, 1,  3, S_MRD,      X_NONE,  3'b000, 0, 0);
        add(1, I_LW,   0, 1,  4, S_RW,       X_MWB,   3'b000, 0, 0);
        // sw zero-wait
        add(1, I_SW,   0, 1,  0, S_FETCH_OK, X_FETCH, 3'b001, 0, 0);
        add(1, I_SW,   0, 0,  1, S_NONE,     X_DEC,   3'b001, 0, 0);
        add(1, I_SW,   0, 0,  2, S_NONE,     X_MADR,  3'b001, 0, 0);
        add(1, I_SW,   0, 1,  5, S_MWR,      X_NONE,  3'b001, 0, 0);
        // beq taken / not taken
        add(1, I_BEQ,  1, 1,  0, S_FETCH_OK, X_FETCH, 3'b010, 0, 0);
        add(1, I_BEQ,  1, 0,  1, S_NONE,     X_DEC,   3'b010, 0, 0);
        add(1, I_BEQ,  1, 0,  9, S_PCW,      X_BR,    3'b010, 0, 0);
        add(1, I_BEQ,  0, 1,  0, S_FETCH_OK, X_FETCH, 3'b010, 0, 0);
        add(1, I_BEQ,  0, 0,  1, S_NONE,     X_DEC,   3'b010, 0, 0);
        add(1, I_BEQ,  0, 0,  9, S_NONE,     X_BR,    3'b010, 0, 0);
        // bne taken (zero=0) / not taken (zero=1)
        add(1, I_BNE,  0, 1,  0, S_FETCH_OK, X_FETCH, 3'b010, 0, 0);
        add(1, I_BNE,  0, 0,  1, S_NONE,     X_DEC,   3'b010, 0, 0);
        add(1, I_BNE,  0, 0,  9, S_PCW,      X_BR,    3'b010, 0, 0);
        add(1, I_BNE,  1, 1,  0, S_FETCH_OK, X_FETCH, 3'b010, 0, 0);
        add(1, I_BNE,  1, 0,  1, S_NONE,     X_DEC,   3'b010, 0, 0);
        add(1, I_BNE,  1, 0,  9, S_NONE,     X_BR,    3'b010, 0, 0);
        // jal: 0,1,10,8
        add(1, I_JAL,  0, 1,  0, S_FETCH_OK, X_FETCH, 3'b100, 0, 0);
        add(1, I_JAL,  0, 0,  1, S_NONE,     X_DEC,   3'b100, 0, 0);
        add(1, I_JAL,  0, 0, 10, S_PCW,      X_JAL,   3'b100, 0, 0);
        add(1, I_JAL,  0, 0,  8, S_RW,       X_NONE,  3'b100, 0, 0);
        // R-type
        add(1, I_ADD,  0, 1,  0, S_FETCH_OK, X_FETCH, 3'b000, 0, 0);
        add(1, I_ADD,  0, 0,  1, S_NONE,     X_DEC,   3'b000, 0, 0);
        add(1, I_ADD,  0, 0,  6, S_NONE,     X_EXR,   3'b000, 0, 0);
        add(1, I_ADD,  0, 0,  8, S_RW,       X_NONE,  3'b000, 0, 0);
        // lui / auipc
        add(1, I_LUI,  0, 1,  0, S_FETCH_OK, X_FETCH, 3'b011, 0, 0);
        add(1, I_LUI,  0, 0,  1, S_NONE,     X_DEC,   3'b011, 0, 0);
        add(1, I_LUI,  0, 0, 11, S_NONE,     X_LUI,   3'b011, 0, 0);
        add(1, I_LUI,  0, 0,  8, S_RW,       X_NONE,  3'b011, 0, 0);
        add(1, I_AUIPC,0, 1,  0, S_FETCH_OK, X_FETCH, 3'b011, 0, 0);
        add(1, I_AUIPC,0, 0,  1, S_NONE,     X_DEC,   3'b011, 0, 0);
        add(1, I_AUIPC,0, 0, 11, S_NONE,     X_AUI,   3'b011, 0, 0);
        add(1, I_AUIPC,0, 0,  8, S_RW,       X_NONE,  3'b011, 0, 0);
        // addi: ready arrives on the 4th request cycle, same cycle as the limit
        add(1, I_ADDI, 0, 0,  0, S_FETCH_WT, X_FETCH, 3'b000, 0, 0);
        add(1, I_ADDI, 0, 0,  0, S_FETCH_WT, X_FETCH, 3'b000, 0, 0);
        add(1, I_ADDI, 0, 0,  0, S_FETCH_WT, X_FETCH, 3'b000, 0, 0);
        add(1, I_ADDI, 0, 1,  0, S_FETCH_OK, X_FETCH, 3'b000, 0, 0);
        add(1, I_ADDI, 0, 0,  1, S_NONE,     X_DEC,   3'b000, 0, 0);
        add(1, I_ADDI, 0, 0,  7, S_NONE,     X_EXI,   3'b000, 0, 0);
        add(1, I_ADDI, 0, 0,  8, S_RW,       X_NONE,  3'b000, 0, 0);
        // sw aborted by reset while waiting in MEMWRITE
        add(1, I_SW,   0, 1,  0, S_FETCH_OK, X_FETCH, 3'b001, 0, 0);
        add(1, I_SW,   0, 0,  1, S_NONE,     X_DEC,   3'b001, 0, 0);
        add(1, I_SW,   0, 0,  2, S_NONE,     X_MADR,  3'b001, 0, 0);
        add(1, I_SW,   0, 0,  5, S_MWR,      X_NONE,  3'b001, 0, 0);
        add(0, I_SW,   0, 0,  5, S_NONE,     X_NONE,  3'b000, 0, 0);
        add(0, I_SW,   0, 1,  0, S_NONE,     X_NONE,  3'b000, 0, 0);
        // illegal opcode: sticky until a one-edge reset
        add(1, I_ILL,  0, 1,  0, S_FETCH_OK, X_FETCH, 3'b000, 0, 0);
        add(1, I_ILL,  0, 0,  1, S_NONE,     X_DEC,   3'b000, 0, 0);
        add(1, I_ILL,  0, 0, 12, S_NONE,     X_NONE,  3'b000, 1, 0);
        add(1, I_ILL,  1, 1, 12, S_NONE,     X_NONE,  3'b000, 1, 0);
        add(0, I_ILL,  0, 1, 12, S_NONE,     X_NONE,  3'b000, 1, 0);
        // unsupported branch funct3 (blt)
        add(1, I_BLT,  0, 0,  0, S_FETCH_WT, X_FETCH, 3'b010, 0, 0);
        add(1, I_BLT,  0, 1,  0, S_FETCH_OK, X_FETCH, 3'b010, 0, 0);
        add(1, I_BLT,  0, 0,  1, S_NONE,     X_DEC,   3'b010, 0, 0);
        add(1, I_BLT,  0, 0, 12, S_NONE,     X_NONE,  3'b010, 1, 0);
        add(0, I_BLT,  0, 0, 12, S_NONE,     X_NONE,  3'b000, 1, 0);
        add(1, I_ADDI, 0, 1,  0, S_FETCH_OK, X_FETCH, 3'b000, 0, 0);

        // Two reset edges before the table starts
        @(posedge clk);
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n     = vecs[i].rn;
            instr     = vecs[i].ins;
            zero      = vecs[i].z;
            mem_ready = vecs[i].rdy;
            #2;
            $display("row %0d: rst_n=%0b instr=%h rdy=%0b state=%0d ctrl=%h",
                     i, rst_n, instr, mem_ready, state, got_ctrl());
            checks++;
            if (state !== vecs[i].st) begin
                failures++;
                $display("FAIL row%0d state got=%0d exp=%0d", i, state, vecs[i].st);
            end
            checks++;
            if (got_ctrl() !== vecs[i].ctrl) begin
                failures++;
                $display("FAIL row%0d ctrl got=%b exp=%b", i, got_ctrl(), vecs[i].ctrl);
            end
        end

        // Hand-written: fetch timeout with WAIT_TIMEOUT = 4
        begin
            int  req_cycles;
            logic ir_seen;
            logic reached;
            @(negedge clk);
            rst_n     = 1'b0;
            instr     = I_ADDI;
            mem_ready = 1'b0;
            @(negedge clk);
            rst_n      = 1'b1;
            req_cycles = 0;
            ir_seen    = 1'b0;
            reached    = 1'b0;
            for (int c = 0; c < 20; c++) begin
                #2;
                if (state == 4'd12) begin
                    reached = 1'b1;
                    break;
                end
                if (mem_req) req_cycles++;
                if (ir_write) ir_seen = 1'b1;
                @(negedge clk);
            end
            $display("timeout: reached_trap=%0b req_cycles=%0d bus_err=%0b", reached, req_cycles, bus_err);
            check_bit("timeout_reached", reached, 1'b1);
            checks++;
            if (req_cycles != 4) begin
                failures++;
                $display("FAIL timeout_req_cycles got=%0d exp=4", req_cycles);
            end
            check_bit("timeout_bus_err", bus_err, 1'b1);
            check_bit("timeout_no_ir_write", ir_seen, 1'b0);
            check_bit("timeout_illegal_clear", illegal, 1'b0);
            // Late ready in TRAP is ignored
            @(negedge clk);
            mem_ready = 1'b1;
            #2;
            $display("trap hold: state=%0d ir_write=%0b bus_err=%0b", state, ir_write, bus_err);
            check_bit("trap_ir_write", ir_write, 1'b0);
            check_bit("trap_bus_err_sticky", bus_err, 1'b1);
            // One reset edge clears the sticky error
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n     = 1'b1;
            mem_ready = 1'b0;
            #2;
            $display("after reset: state=%0d bus_err=%0b", state, bus_err);
            check_bit("reset_bus_err", bus_err, 1'b0);
            check_bit("reset_state_fetch", (state == 4'd0), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
